// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and the round-robin first-set search for the multiplier-sharing arbiter.
package mult_share_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int RR_MAX_REQ = 8;
  localparam int RR_PTR_W   = 3;

  // Returns the first set index of mask scanning ptr, ptr+1, ... modulo n; -1 when none is set.
  function automatic int rr_first(input logic [RR_MAX_REQ-1:0] mask,
                                  input logic [RR_PTR_W-1:0]   ptr,
                                  input int                    n);
    int r;
    int k;
    r = -1;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (r < 0 && i < n && mask[k]) r = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of mask at or after ptr, wrapping.
module mult_share_arbiter_rr_pick
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         mask,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [RR_MAX_REQ-1:0] mask_w;
  logic [RR_PTR_W-1:0]   ptr_w;
  int                    r;

  always_comb begin
    mask_w              = '0;
    mask_w[NUM_REQ-1:0] = mask;
    ptr_w               = '0;
    ptr_w[IDW-1:0]      = ptr;
  end

  assign r     = rr_first(mask_w, ptr_w, NUM_REQ);
  assign found = (r >= 0);
  assign idx   = IDW'(r);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin owner of one shared signed multiplier with a per-burst hold limit.
// Define MULT_SHARE_ARBITER_PIPE_EN to register MULT_OUT/PROD_VALID/PROD_ID one cycle behind GNT.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BITWIDTH_A = 16,
  parameter int BITWIDTH_B = 16,
  parameter int MAX_HOLD   = 512
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NUM_REQ-1:0]                      REQ,
  input  logic [NUM_REQ*BITWIDTH_A-1:0]           INA,
  input  logic [NUM_REQ*BITWIDTH_B-1:0]           INB,
  output logic [NUM_REQ-1:0]                      GNT,
  output logic signed [BITWIDTH_A+BITWIDTH_B-1:0] MULT_OUT,
  output logic                                    PROD_VALID,
  output logic [$clog2(NUM_REQ)-1:0]              PROD_ID,
  output logic                                    BUSY,
  output arb_state_e                              dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HCW = $clog2(MAX_HOLD);
  localparam int PW  = BITWIDTH_A + BITWIDTH_B;

  arb_state_e               state;
  logic [IDW-1:0]           owner;
  logic [IDW-1:0]           ptr;
  logic [HCW-1:0]           hold_cnt;
  logic [IDW-1:0]           pick_idx;
  logic                     pick_found;
  logic [IDW-1:0]           alt_idx;
  logic                     alt_found;
  logic [NUM_REQ-1:0]       alt_mask;
  logic signed [BITWIDTH_A-1:0] op_a;
  logic signed [BITWIDTH_B-1:0] op_b;
  logic signed [PW-1:0]     a_ext;
  logic signed [PW-1:0]     b_ext;
  logic signed [PW-1:0]     prod;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // On hold expiry the current owner is hidden so any other waiting requester takes over.
  assign alt_mask = REQ & ~(NUM_REQ'(1) << owner);

  mult_share_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask  (REQ),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  mult_share_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_alt (
    .mask  (alt_mask),
    .ptr   (ptr),
    .idx   (alt_idx),
    .found (alt_found)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            owner    <= pick_idx;
            ptr      <= wrap_inc(pick_idx);
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!REQ[owner]) begin
            if (pick_found) begin
              owner    <= pick_idx;
              ptr      <= wrap_inc(pick_idx);
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt < HCW'(MAX_HOLD - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
            if (alt_found) begin
              owner <= alt_idx;
              ptr   <= wrap_inc(alt_idx);
            end else begin
              ptr <= wrap_inc(owner);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign GNT       = (state == GRANT) ? (NUM_REQ'(1) << owner) : '0;
  assign BUSY      = (state == GRANT);
  assign dbg_state = state;

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == GRANT) begin
      op_a = INA[owner*BITWIDTH_A +: BITWIDTH_A];
      op_b = INB[owner*BITWIDTH_B +: BITWIDTH_B];
    end
  end

  assign a_ext = PW'(op_a);
  assign b_ext = PW'(op_b);
  assign prod  = a_ext * b_ext;

  // PROD_VALID marks the cycle in which MULT_OUT carries the product of requester PROD_ID;
  // there is no back-pressure, the owning requester must sample it in that cycle.
`ifdef MULT_SHARE_ARBITER_PIPE_EN
  logic signed [PW-1:0] prod_q;
  logic                 valid_q;
  logic [IDW-1:0]       id_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      prod_q  <= prod;
      valid_q <= (state == GRANT);
      id_q    <= owner;
    end
  end

  assign MULT_OUT   = prod_q;
  assign PROD_VALID = valid_q;
  assign PROD_ID    = id_q;
`else
  assign MULT_OUT   = prod;
  assign PROD_VALID = BUSY;
  assign PROD_ID    = owner;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised and directed bench for mult_share_arbiter against a queue-based ownership model.
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int BA  = 16;
  localparam int BB  = 16;
  localparam int MH  = 4;
  localparam int PW  = BA + BB;
  localparam int IDW = 2;
`ifdef MULT_SHARE_ARBITER_PIPE_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*BA-1:0] ina;
  logic [N*BB-1:0] inb;
  logic [N-1:0]    gnt;
  logic [PW-1:0]   mult_out;
  logic            prod_valid;
  logic [IDW-1:0]  prod_id;
  logic            busy;
  arb_state_e      dbg_state;

  mult_share_arbiter #(
    .NUM_REQ(N), .BITWIDTH_A(BA), .BITWIDTH_B(BB), .MAX_HOLD(MH)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .INA(ina), .INB(inb),
    .GNT(gnt), .MULT_OUT(mult_out), .PROD_VALID(prod_valid),
    .PROD_ID(prod_id), .BUSY(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint prod_of(input int k, input logic [N*BA-1:0] a_v,
                                     input logic [N*BB-1:0] b_v);
    logic signed [BA-1:0] a;
    logic signed [BB-1:0] b;
    a = a_v[k*BA +: BA];
    b = b_v[k*BB +: BB];
    return longint'(a) * longint'(b);
  endfunction

  // behavioural model: who owns the multiplier and for how many cycles so far
  int m_owner = -1;
  int m_used  = 0;
  int m_last  = -1;
  int nx_owner, nx_used, nx_last;

  function automatic int pick(input int start, input logic [N-1:0] r, input int excl);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  always_comb begin
    int   cand;
    logic keep;
    nx_owner = -1;
    nx_used  = 0;
    nx_last  = m_last;
    cand     = -1;
    keep     = 1'b0;
    if (m_owner >= 0) begin
      if (req[m_owner]) begin
        if (m_used < MH) keep = 1'b1;
        else begin
          cand = pick(m_last + 1, req, m_owner);
          if (cand < 0) cand = m_owner;
        end
      end else begin
        cand = pick(m_last + 1, req, -1);
      end
    end else begin
      cand = pick(m_last + 1, req, -1);
    end
    if (keep) begin
      nx_owner = m_owner;
      nx_used  = m_used + 1;
    end else if (cand >= 0) begin
      nx_owner = cand;
      nx_used  = 1;
      nx_last  = cand;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_used  <= 0;
      m_last  <= -1;
    end else begin
      m_owner <= nx_owner;
      m_used  <= nx_used;
      m_last  <= nx_last;
    end
  end

  // scoreboard: expected {valid, id, product}, delayed by the product latency
  logic [PW+IDW:0] exp_q[$];

  always @(negedge clk) begin
    logic [PW+IDW:0] e;
    check("gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
    check("busy", busy, (m_owner >= 0) ? 1 : 0);
    check("state", int'(dbg_state), (m_owner >= 0) ? int'(GRANT) : int'(IDLE));
    if (rst) exp_q.delete();
    e = '0;
    if (m_owner >= 0) begin
      e[PW+IDW]      = 1'b1;
      e[PW +: IDW]   = IDW'(m_owner);
      e[PW-1:0]      = PW'(prod_of(m_owner, ina, inb));
    end
    exp_q.push_back(e);
    if (exp_q.size() > LAG) begin
      e = exp_q.pop_front();
      check("prod_valid", prod_valid, e[PW+IDW]);
      if (e[PW+IDW]) check("prod_id", prod_id, e[PW +: IDW]);
      check("mult_out", longint'($signed(mult_out)), longint'($signed(e[PW-1:0])));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    ina[k*BA +: BA] = a[BA-1:0];
    inb[k*BB +: BB] = b[BB-1:0];
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ina = '0;
    inb = '0;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", prod_valid, 0);
    check("rst_mult", longint'($signed(mult_out)), 0);
    check("rst_id", prod_id, 0);

    // single requester, 3 * -5
    rst = 1'b0;
    req = 4'b0001;
    set_op(0, 3, -5);
    tick();
    check("t1_gnt", gnt, 1);
    check("t1_busy", busy, 1);
`ifdef MULT_SHARE_ARBITER_PIPE_EN
    tick();
`endif
    check("t1_mult", longint'($signed(mult_out)), -15);
    check("t1_valid", prod_valid, 1);
    check("t1_id", prod_id, 0);

    // two requesters from idle, direct handover
    req = '0;
    pulse_reset();
    req = 4'b1010;
    tick();
    check("t2_first", gnt, 4'b0010);
    tick();
    req = 4'b1000;
    tick();
    check("t2_handover", gnt, 4'b1000);
    check("t2_busy", busy, 1);
    req = 4'b0000;
    tick();
    check("t2_idle_gnt", gnt, 0);
    check("t2_idle_busy", busy, 0);

    // all requesting: rotation in bursts of MH cycles
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_rotate", gnt, 1 << ((i / MH) % N));
    end

    // lone requester re-granted without gap, extreme operands
    req = 4'b0100;
    set_op(2, -32768, -32768);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_lone", gnt, 4'b0100);
      if (i == 5) check("t4_extreme", longint'($signed(mult_out)), 64'sd1073741824);
    end

    // asynchronous reset mid-burst
    rst = 1'b1;
    #1;
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", prod_valid, 0);
    tick();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("t5_restart", gnt, 4'b0001);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if ($urandom_range(0, 5) == 0) req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
        end
        set_op(k, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      end
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else tick();
    end

    req = '0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
